// File: rtl/wave_capture.sv
// Writer side of the double-buffered wave RAM: arms on a rising zero crossing, captures
// 2^DEPTH_LOG2 samples into the half the display is not reading, then flips halves during idle.
module wave_capture #(
   parameter int SAMPLE_W   = 16,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_sample_ready,
   input  logic [SAMPLE_W-1:0]   new_sample_in,
   input  logic                  wave_display_idle,
   output logic [DEPTH_LOG2:0]   write_address,
   output logic                  write_enable,
   output logic [7:0]            write_sample,
   output logic                  read_index
);

   typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] count_q, count_d;
   logic                  prev_sign_q;
   logic                  read_index_d;
   logic                  write_enable_d;
   logic [DEPTH_LOG2:0]   write_address_d;
   logic [7:0]            write_sample_d;
   logic [7:0]            converted;
   logic                  trigger;
   logic                  unused_low_bits;

   // Only the top byte is stored and only the sign is remembered for crossing detection.
   assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];
   assign converted = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
   assign trigger   = new_sample_ready && prev_sign_q && !new_sample_in[SAMPLE_W-1];

   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      read_index_d    = read_index;
      write_enable_d  = 1'b0;
      write_address_d = write_address;
      write_sample_d  = write_sample;
      case (state_q)
         ARMED: begin
            if (trigger) begin
               write_enable_d  = 1'b1;
               write_address_d = {~read_index, {DEPTH_LOG2{1'b0}}};
               write_sample_d  = converted;
               count_d         = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
               state_d         = ACTIVE;
            end
         end
         ACTIVE: begin
            if (new_sample_ready) begin
               write_enable_d  = 1'b1;
               write_address_d = {~read_index, count_q};
               write_sample_d  = converted;
               count_d         = count_q + 1'b1;
               if (count_q == {DEPTH_LOG2{1'b1}})
                  state_d = WAIT;
            end
         end
         WAIT: begin
            // Flip halves only here so the display never scans a partial capture.
            if (wave_display_idle) begin
               read_index_d = ~read_index;
               state_d      = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ARMED;
         count_q       <= '0;
         prev_sign_q   <= 1'b0;
         read_index    <= 1'b0;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_sample  <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         read_index    <= read_index_d;
         write_enable  <= write_enable_d;
         write_address <= write_address_d;
         write_sample  <= write_sample_d;
         if (new_sample_ready)
            prev_sign_q <= new_sample_in[SAMPLE_W-1];
      end
   end

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: expected RAM writes are queued as stimulus is driven
// and checked as the DUT emits them.
module tb_wave_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        new_sample_ready = 1'b0;
   logic [15:0] new_sample_in = 16'h0000;
   logic        wave_display_idle = 1'b0;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;

   int checks = 0;
   int failures = 0;
   logic [16:0] exp_q[$];   // {address, data}

   wave_capture #(.SAMPLE_W(16), .DEPTH_LOG2(8)) dut (
      .clk(clk),
      .reset(reset),
      .new_sample_ready(new_sample_ready),
      .new_sample_in(new_sample_in),
      .wave_display_idle(wave_display_idle),
      .write_address(write_address),
      .write_enable(write_enable),
      .write_sample(write_sample),
      .read_index(read_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs; queue a write if one is expected from it.
   task automatic step(input logic rdy, input logic [15:0] s, input logic idle,
                       input logic exp_we, input logic [8:0] exp_addr, input logic [7:0] exp_dat);
      @(negedge clk);
      new_sample_ready  = rdy;
      new_sample_in     = s;
      wave_display_idle = idle;
      if (exp_we) exp_q.push_back({exp_addr, exp_dat});
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 9'h0, 8'h0);
   endtask

   always @(negedge clk) begin
      logic [16:0] e;
      if (reset && write_enable) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write",
                   write_address, write_sample);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write_address", {23'd0, write_address}, {23'd0, e[16:8]});
            chk("write_sample", {24'd0, write_sample}, {24'd0, e[7:0]});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_we", {31'd0, write_enable}, 32'd0);
      chk("rst_addr", {23'd0, write_address}, 32'd0);
      chk("rst_data", {24'd0, write_sample}, 32'd0);
      chk("rst_ri", {31'd0, read_index}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      quiet(2);

      // First capture: trigger on 0xFF00 -> 0x0100, then 255 x 0x4000
      step(1'b1, 16'hFF00, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'h0100, 1'b0, 1'b1, 9'h100, 8'h81);
      quiet(1);
      chk("ri_after_trigger", {31'd0, read_index}, 32'd0);
      for (int i = 1; i < 256; i++) step(1'b1, 16'h4000, 1'b0, 1'b1, 9'h100 | 9'(i), 8'hC0);
      // Further strobes and a rising crossing in WAIT must not write
      for (int i = 0; i < 3; i++) step(1'b1, 16'h4000, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'hFF00, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'h0100, 1'b0, 1'b0, 9'h0, 8'h0);
      quiet(2);
      chk("ri_before_idle", {31'd0, read_index}, 32'd0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 9'h0, 8'h0);
      quiet(1);
      chk("ri_toggle1", {31'd0, read_index}, 32'd1);

      // Second capture into the lower half; extremes map to 0xFF / 0x00
      step(1'b1, 16'h8000, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'h7FFF, 1'b0, 1'b1, 9'h000, 8'hFF);
      step(1'b1, 16'h8000, 1'b0, 1'b1, 9'h001, 8'h00);
      for (int i = 2; i < 256; i++)
         step(1'b1, {8'(i), 8'h00}, 1'b0, 1'b1, 9'(i), 8'(i) ^ 8'h80);
      step(1'b1, 16'h1234, 1'b0, 1'b0, 9'h0, 8'h0);
      quiet(2);
      chk("ri_wait2", {31'd0, read_index}, 32'd1);

      // Idle and a negative sample together in WAIT, then a trigger on the next sample
      step(1'b1, 16'hFF00, 1'b1, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'h0010, 1'b0, 1'b1, 9'h100, 8'h80);
      quiet(1);
      chk("ri_toggle2", {31'd0, read_index}, 32'd0);

      // Abort a capture after 100 writes with asynchronous reset
      for (int i = 1; i < 100; i++) step(1'b1, 16'h2000, 1'b0, 1'b1, 9'h100 | 9'(i), 8'hA0);
      quiet(1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_we", {31'd0, write_enable}, 32'd0);
      chk("arst_addr", {23'd0, write_address}, 32'd0);
      chk("arst_data", {24'd0, write_sample}, 32'd0);
      chk("arst_ri", {31'd0, read_index}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // ARMED: positive samples and a falling crossing never write; idle is ignored
      step(1'b1, 16'h0100, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'h1234, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'h0100, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b1, 16'hFF00, 1'b0, 1'b0, 9'h0, 8'h0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 9'h0, 8'h0);
      quiet(1);
      step(1'b1, 16'h8000, 1'b1, 1'b0, 9'h0, 8'h0);
      quiet(2);
      chk("ri_armed_idle", {31'd0, read_index}, 32'd0);

      // Capture after reset restarts at count 0 in the upper half
      step(1'b1, 16'h0000, 1'b0, 1'b1, 9'h100, 8'h80);
      step(1'b1, 16'h0000, 1'b0, 1'b1, 9'h101, 8'h80);
      quiet(3);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Writer side of the double-buffered waveform sample RAM that the wave display block reads.
- Watches the audio sample stream and arms on a positive-going zero crossing, then writes 2^DEPTH_LOG2 consecutive 8-bit samples into the half of the RAM the display is not reading.
- Once the display is idle, flips read_index so the display reads the fresh capture.
- Sits between the codec sample path and the dual-port sample RAM; its read_index output drives the display's read_index input.

Parameters:
- SAMPLE_W, 16: width of the signed two's-complement input sample.
- DEPTH_LOG2, 8: log2 of samples per capture. Write address width is DEPTH_LOG2+1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  SAMPLE_W  signed audio sample.
- wave_display_idle  input  1  high while the display is not scanning the wave region (vertical blank).
- write_address  output  DEPTH_LOG2+1  RAM write address, {~read_index, count}.
- write_enable  output  1  RAM write strobe, one cycle per captured sample.
- write_sample  output  8  unsigned sample to store.
- read_index  output  1  RAM half the display reads. The writer always targets the other half.

Behaviour:
- All outputs are registered.
- Reset values: state=ARMED, read_index=0, count=0, prev_sample=0, write_enable=0, write_address=0, write_sample=0.
- Reset is asynchronous. Asserting it mid-capture abandons the partial capture with no further writes.
- prev_sample captures new_sample_in on every new_sample_ready, in all states.
- Trigger condition: new_sample_ready && prev_sample[SAMPLE_W-1]==1 && new_sample_in[SAMPLE_W-1]==0 (negative to non-negative).
- Conversion: write_sample = {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]}. This takes the top 8 bits and flips the MSB, so 0x8000 maps to 0x00, 0x0000 to 0x80, and 0x7FFF to 0xFF.
- State ARMED:
  - Waits for the trigger.
  - On trigger, the triggering sample is written as count 0. On the next cycle: write_enable=1, write_address={~read_index, 0}, write_sample=converted sample. count becomes 1 and state goes to ACTIVE.
- State ACTIVE:
  - Each new_sample_ready produces a write on the next cycle at {~read_index, count}, then count increments.
  - The write of count 2^DEPTH_LOG2-1 (255) wraps count to 0 and moves to WAIT.
  - No trigger check in this state.
- State WAIT:
  - Samples are ignored (no writes) but still update prev_sample.
  - On the first cycle wave_display_idle==1, toggle read_index and go to ARMED.
- wave_display_idle is ignored in ARMED and ACTIVE. read_index changes only on the WAIT-to-ARMED transition, so the display never sees a half-written buffer.
- Simultaneous events:
  - wave_display_idle and new_sample_ready in the same WAIT cycle: the toggle happens, the sample is not written, and prev_sample is updated. That sample can therefore serve as prev for a trigger on the very next sample.
  - new_sample_ready on the same cycle ACTIVE writes its last sample: the write is taken, then the state is WAIT.
- write_enable is 0 on every cycle without an accepted sample. A new_sample_ready held high for multiple cycles counts as one sample per cycle.
- Latency: sample strobe to RAM write is 1 cycle. Capture of 256 samples takes exactly 256 new_sample_ready strobes, including the trigger.

Test Plan:
- Reset, then feed samples 0xFF00, 0x0100 -> write at address 0x100 with write_sample 0x81; state ACTIVE; read_index stays 0.
- After the trigger, feed 255 more samples of 0x4000 -> writes at addresses 0x101..0x1FF, all write_sample 0xC0. No 257th write even with further strobes; wave_display_idle pulse -> read_index=1.
- Second capture after the toggle -> writes land at addresses 0x000..0x0FF. Samples 0x8000 and 0x7FFF map to 0x00 and 0xFF.
- Samples strictly positive or a falling crossing (0x0100 then 0xFF00) in ARMED -> no write_enable ever; wave_display_idle pulses -> read_index unchanged.
- Assert reset low after 100 captured writes -> outputs return to reset values immediately (asynchronous); the next capture starts at address 0x100 with count 0.
- In WAIT, drive wave_display_idle and a 0xFF00 strobe in the same cycle, then a 0x0010 strobe next -> read_index toggles, no write for 0xFF00, and 0x0010 triggers a write of 0x80 at address {~read_index, 0}.
